led_blink_scheduler: RTL and testbench
======================================

// Module: led_blink_scheduler
// PURPOSE
//  Shares one status LED between NUM_REQ requesters. Each requester asks for a burst of N blinks.
//  A round-robin arbiter grants one burst at a time. An FSM sequences ON/OFF/GAP phases on a
//  prescaled tick, and the requester gets a one-cycle done acknowledge. Sits between status
//  sources (link-up, error, heartbeat) and the board LED pin.
// PARAMETERS
//  CLK_FREQ_HZ  100_000_000  input clock frequency
//  TICK_HZ      10           phase tick rate; TICK_CYCLES = CLK_FREQ_HZ/TICK_HZ, must be >= 2
//  NUM_REQ      4            number of requesters, >= 2
//  CNT_W        4            width of each blink-count field
//  ON_TICKS     1            ticks LED is lit per blink, >= 1
//  OFF_TICKS    1            ticks LED is dark between blinks, >= 1
//  GAP_TICKS    2            dark ticks after last blink before done, >= 1
// PORTS
//  clk       in   1              single clock domain
//  rst       in   1              synchronous, active-high reset
//  req       in   NUM_REQ        level request per requester
//  count     in   NUM_REQ*CNT_W  blink count, requester i at [i*CNT_W +: CNT_W]; held stable while req[i]=1
//  grant     out  NUM_REQ        one-hot, high for the whole granted burst
//  done      out  NUM_REQ        one-cycle completion pulse to the served requester
//  busy      out  1              FSM not in IDLE
//  led_out   out  1              registered LED drive
// BEHAVIOUR
//  Reset: state=IDLE, led_out=0, grant=0, done=0, busy=0, prescaler=0, rr pointer set so req[0] has top priority.
//  States: IDLE, ON, OFF, GAP, DONE. All outputs are registered.
//  IDLE, |req=1 at cycle k: pick the first set req at or after rr_ptr (wrapping). Latch count[i] into remaining. Set rr_ptr=(i+1) mod NUM_REQ.
//    count!=0 -> ON at k+1: grant[i]=1, led_out=1, prescaler cleared.
//    count==0 -> DONE at k+1; grant never asserts and led_out stays 0.
//  Tick: prescaler counts 0..TICK_CYCLES-1 and wraps. tick=1 when prescaler==TICK_CYCLES-1.
//    Prescaler is cleared on every IDLE->ON entry, so phases are exact multiples of TICK_CYCLES.
//  ON: led_out=1. After ON_TICKS ticks -> OFF.
//  OFF: led_out=0. After OFF_TICKS ticks, decrement remaining.
//    If the decremented value is 0 -> GAP, else -> ON.
//  GAP: led_out=0. After GAP_TICKS ticks -> DONE.
//  DONE: one cycle. grant=0, done[i]=1, busy=1 -> IDLE. Next grant no earlier than 2 cycles after done.
//  Grant duration for count n = (n*(ON_TICKS+OFF_TICKS)+GAP_TICKS)*TICK_CYCLES cycles.
//  req[i] dropped mid-burst: ignored. The burst completes and done still pulses. No abort.
//  req[i] still high after done: eligible again, but only after every other active requester (round robin).
//  count changes while granted: ignored, the latched value is used.
//  count = 2^CNT_W-1: exactly that many blinks. Counters must not wrap or underflow.
//  rst mid-burst: next cycle all outputs take reset values, no done is issued, rr pointer resets.
//  Phase tick counter width = $clog2(max(ON,OFF,GAP)_TICKS+1). Prescaler width = $clog2(TICK_CYCLES).
// STRUCTURE
//  Package led_ctrl_pkg:
//    state enum {IDLE,ON,OFF,GAP,DONE}
//    localparam functions for TICK_CYCLES and the counter widths
//  Sub-module led_tick_gen:
//    prescaler with sync clear, outputs a 1-cycle tick
//    parameter TICK_CYCLES, ports clk, rst, clr, tick
//  Top contains the round-robin arbiter, FSM, remaining counter and phase tick counter.
// TESTING  (CLK_FREQ_HZ=40, TICK_HZ=10 -> TICK_CYCLES=4; NUM_REQ=4, CNT_W=4, ON=OFF=1, GAP=2)
//  1. Single burst: req[0]=1, count0=3 at cycle k.
//     -> grant[0] over k+1..k+32.
//     -> led_out high k+1..4, k+9..12, k+17..20, otherwise low.
//     -> done[0] at k+33 only; busy low at k+34.
//  2. Round robin: from reset, req[0], req[2] set together with count=1.
//     -> grant order 0 then 2.
//     -> then all four req held high: order 3,0,1,2,3...
//  3. Zero count: req[1]=1, count1=0 at k.
//     -> grant stays 0, led_out stays 0, done[1] at k+1, IDLE at k+2.
//  4. Mid-burst drop: req[0] dropped at k+5 of a count=2 burst.
//     -> burst completes unchanged, done[0] at k+1+16+8.
//  5. Reset mid-burst: rst=1 for one cycle during ON.
//     -> next cycle led_out=0, grant=0, done=0, busy=0.
//     -> req[0] then served first.
//  6. Max count: count=15.
//     -> exactly 15 led_out rising edges, done after 128 grant cycles.
//     -> no extra blink from counter wrap.

Source files
------------

// File: rtl/led_ctrl_pkg.sv
// Shared types and elaboration-time sizing helpers for the LED blink scheduler.
package led_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ON   = 3'd1,
        OFF  = 3'd2,
        GAP  = 3'd3,
        DONE = 3'd4
    } state_e;

    // Clock cycles per phase tick.
    function automatic int unsigned calc_tick_cycles(input int unsigned clk_hz, input int unsigned tick_hz);
        return clk_hz / tick_hz;
    endfunction

    // Prescaler width; never narrower than one bit.
    function automatic int unsigned calc_pre_w(input int unsigned tick_cycles);
        return (tick_cycles <= 1) ? 1 : $clog2(tick_cycles);
    endfunction

    // Phase tick counter width, sized for the longest phase.
    function automatic int unsigned calc_phase_w(input int unsigned on_t, input int unsigned off_t,
                                                 input int unsigned gap_t);
        int unsigned m;
        m = on_t;
        if (off_t > m) m = off_t;
        if (gap_t > m) m = gap_t;
        return $clog2(m + 1);
    endfunction

    // Requester index width.
    function automatic int unsigned calc_idx_w(input int unsigned num_req);
        return (num_req <= 1) ? 1 : $clog2(num_req);
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Free-running prescaler with synchronous clear; pulses tick on its last count.
module led_tick_gen
    import led_ctrl_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned PRE_W = calc_pre_w(TICK_CYCLES);

    logic [PRE_W-1:0] r_pre;

    // Count 0..TICK_CYCLES-1 and wrap; clr restarts the tick grid.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_pre <= '0;
        end else if (r_pre == PRE_W'(TICK_CYCLES - 1)) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + PRE_W'(1);
        end
    end

    assign tick = (r_pre == PRE_W'(TICK_CYCLES - 1));

endmodule

// File: rtl/led_blink_scheduler.sv
// Round-robin arbitration of blink bursts onto a single status LED.
module led_blink_scheduler
    import led_ctrl_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned TICK_HZ     = 10,
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned CNT_W       = 4,
    parameter int unsigned ON_TICKS    = 1,
    parameter int unsigned OFF_TICKS   = 1,
    parameter int unsigned GAP_TICKS   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*CNT_W-1:0] count,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       done,
    output logic                     busy,
    output logic                     led_out
);

    localparam int unsigned TICK_CYCLES = calc_tick_cycles(CLK_FREQ_HZ, TICK_HZ);
    localparam int unsigned PH_W        = calc_phase_w(ON_TICKS, OFF_TICKS, GAP_TICKS);
    localparam int unsigned IDX_W       = calc_idx_w(NUM_REQ);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [IDX_W-1:0]   r_sel;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [CNT_W-1:0]   r_remaining;
    logic [PH_W-1:0]    r_phase;
    logic [NUM_REQ-1:0] r_grant;
    logic [NUM_REQ-1:0] r_done;
    logic               r_busy;
    logic               r_led;

    logic               w_tick;
    logic               w_clr;
    logic               w_phase_end;
    logic               w_arb_found;
    logic [IDX_W-1:0]   w_arb_sel;
    logic [CNT_W-1:0]   w_count_sel;
    logic [IDX_W-1:0]   w_sel_nxt;
    logic [NUM_REQ-1:0] w_onehot;

    led_tick_gen #(
        .TICK_CYCLES (TICK_CYCLES)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_clr),
        .tick (w_tick)
    );

    // Round-robin search: first set request at or after the pointer, wrapping.
    always_comb begin
        w_arb_found = 1'b0;
        w_arb_sel   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!w_arb_found && req[(32'(r_rr_ptr) + i) % NUM_REQ]) begin
                w_arb_found = 1'b1;
                w_arb_sel   = IDX_W'((32'(r_rr_ptr) + i) % NUM_REQ);
            end
        end
    end

    // Blink count of the requester being picked this cycle.
    always_comb begin
        w_count_sel = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_arb_sel == IDX_W'(i)) begin
                w_count_sel = count[i*CNT_W +: CNT_W];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; phase_end marks the final tick of the current phase.
    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        w_phase_end = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_arb_found) begin
                    if (w_count_sel != '0) begin
                        w_state_nxt = ON;
                        w_clr       = 1'b1;
                    end else begin
                        w_state_nxt = DONE;
                    end
                end
            end
            ON: begin
                w_phase_end = w_tick && (r_phase == PH_W'(ON_TICKS - 1));
                if (w_phase_end) w_state_nxt = OFF;
            end
            OFF: begin
                w_phase_end = w_tick && (r_phase == PH_W'(OFF_TICKS - 1));
                if (w_phase_end) begin
                    w_state_nxt = (r_remaining == CNT_W'(1)) ? GAP : ON;
                end
            end
            GAP: begin
                w_phase_end = w_tick && (r_phase == PH_W'(GAP_TICKS - 1));
                if (w_phase_end) w_state_nxt = DONE;
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Latch the winner and advance the round-robin pointer past it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel    <= '0;
            r_rr_ptr <= '0;
        end else if (r_state == IDLE && w_arb_found) begin
            r_sel    <= w_arb_sel;
            r_rr_ptr <= IDX_W'((32'(w_arb_sel) + 1) % NUM_REQ);
        end
    end

    // Remaining blinks: loaded at grant, decremented at the end of each OFF.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_remaining <= '0;
        end else if (r_state == IDLE && w_arb_found) begin
            r_remaining <= w_count_sel;
        end else if (r_state == OFF && w_phase_end) begin
            r_remaining <= r_remaining - CNT_W'(1);
        end
    end

    // Ticks elapsed in the current phase; restarts on every state change.
    always_ff @(posedge clk) begin
        if (rst || (w_state_nxt != r_state)) begin
            r_phase <= '0;
        end else if (w_tick && (r_state == ON || r_state == OFF || r_state == GAP)) begin
            r_phase <= r_phase + PH_W'(1);
        end
    end

    assign w_sel_nxt = (r_state == IDLE) ? w_arb_sel : r_sel;
    assign w_onehot  = NUM_REQ'(1) << w_sel_nxt;

    // Outputs registered from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant <= '0;
            r_done  <= '0;
            r_busy  <= 1'b0;
            r_led   <= 1'b0;
        end else begin
            r_grant <= (w_state_nxt == ON || w_state_nxt == OFF || w_state_nxt == GAP) ? w_onehot : '0;
            r_done  <= (w_state_nxt == DONE) ? w_onehot : '0;
            r_busy  <= (w_state_nxt != IDLE);
            r_led   <= (w_state_nxt == ON);
        end
    end

    assign grant   = r_grant;
    assign done    = r_done;
    assign busy    = r_busy;
    assign led_out = r_led;

endmodule

// File: tb/tb_led_blink_scheduler.sv
// Self-checking bench: cycle-exact checks plus a burst scoreboard.
module tb_led_blink_scheduler;

    localparam int unsigned NR = 4;
    localparam int unsigned CW = 4;

    typedef struct packed {
        logic [NR-1:0] done_v;
        logic [NR-1:0] gseen;
        logic [15:0]   len;
        logic [7:0]    blinks;
    } burst_t;

    logic             clk;
    logic             rst;
    logic [NR-1:0]    req;
    logic [NR*CW-1:0] count;
    logic [NR-1:0]    grant;
    logic [NR-1:0]    done;
    logic             busy;
    logic             led_out;

    int n_tests = 0;
    int n_fail  = 0;

    burst_t exp_q[$];
    burst_t obs_q[$];

    logic [NR-1:0] m_gseen;
    int            m_len;
    int            m_blinks;
    logic          m_led_d;

    led_blink_scheduler #(
        .CLK_FREQ_HZ (40),
        .TICK_HZ     (10),
        .NUM_REQ     (NR),
        .CNT_W       (CW),
        .ON_TICKS    (1),
        .OFF_TICKS   (1),
        .GAP_TICKS   (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .count   (count),
        .grant   (grant),
        .done    (done),
        .busy    (busy),
        .led_out (led_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: summarise each burst and push it when done pulses.
    always @(negedge clk) begin
        if (rst) begin
            m_gseen  = '0;
            m_len    = 0;
            m_blinks = 0;
            m_led_d  = 1'b0;
        end else begin
            if (grant != '0) m_len = m_len + 1;
            m_gseen = m_gseen | grant;
            if (led_out && !m_led_d) m_blinks = m_blinks + 1;
            m_led_d = led_out;
            if (done != '0) begin
                obs_q.push_back('{done, m_gseen, 16'(m_len), 8'(m_blinks)});
                m_gseen  = '0;
                m_len    = 0;
                m_blinks = 0;
            end
        end
    end

    function automatic string fmt(input burst_t b);
        return $sformatf("done=%b grant=%b len=%0d blinks=%0d", b.done_v, b.gseen, b.len, b.blinks);
    endfunction

    task automatic wait_obs(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < max_cycles; c++) begin
            if (obs_q.size() != 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (obs_q.size() != 0) ok = 1'b1;
    endtask

    task automatic apply_reset();
        rst   = 1'b1;
        req   = '0;
        count = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [2*NR+1:0] got;
        rst   = 1'b1;
        req   = '1;
        count = '1;
        repeat (2) @(negedge clk);
        got = {grant, done, busy, led_out};
        n_tests++;
        if (got !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want %b", got, {(2*NR+2){1'b0}});
        end
        req   = '0;
        rst   = 1'b0;
        repeat (2) @(negedge clk);
        got = {grant, done, busy, led_out};
        n_tests++;
        if (got !== '0) begin
            n_fail++;
            $display("FAIL reset_idle: got %b want %b", got, {(2*NR+2){1'b0}});
        end
    endtask

    task automatic test_single_burst();
        logic [2*NR+1:0] got, want;
        burst_t e, o;
        bit ok;
        apply_reset();
        count[3:0] = 4'd3;
        req        = 4'b0001;
        exp_q.push_back('{4'b0001, 4'b0001, 16'd32, 8'd3});
        for (int j = 1; j <= 34; j++) begin
            @(negedge clk);
            want = {((j <= 32) ? 4'b0001 : 4'b0000),
                    ((j == 33) ? 4'b0001 : 4'b0000),
                    (j <= 33),
                    ((j >= 1 && j <= 4) || (j >= 9 && j <= 12) || (j >= 17 && j <= 20))};
            got = {grant, done, busy, led_out};
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL single_cycle_%0d: got grant/done/busy/led=%b want %b", j, got, want);
            end
            if (j == 33) req = '0;
        end
        wait_obs(10, ok);
        e = exp_q.pop_front();
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL single_sb: no burst observed, want %s", fmt(e));
        end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
                n_fail++;
                $display("FAIL single_sb: got %s want %s", fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_round_robin();
        burst_t e, o;
        bit ok;
        int order[7] = '{0, 2, 3, 0, 1, 2, 3};
        apply_reset();
        count = {4{4'd1}};
        req   = 4'b0101;
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back('{4'(1 << order[i]), 4'(1 << order[i]), 16'd16, 8'd1});
        end
        for (int i = 0; i < 7; i++) begin
            wait_obs(40, ok);
            e = exp_q.pop_front();
            n_tests++;
            if (!ok) begin
                n_fail++;
                $display("FAIL rr_%0d: no burst observed, want %s", i, fmt(e));
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL rr_%0d: got %s want %s", i, fmt(o), fmt(e));
                end
            end
            if (i == 0) req[0] = 1'b0;
            if (i == 1) req = 4'b1111;
            if (i == 6) req = '0;
        end
        repeat (4) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_idle: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_zero_count();
        logic [2*NR+1:0] got;
        burst_t e, o;
        bit ok;
        apply_reset();
        count[7:4] = 4'd0;
        req        = 4'b0010;
        exp_q.push_back('{4'b0010, 4'b0000, 16'd0, 8'd0});
        @(negedge clk);
        got = {grant, done, busy, led_out};
        n_tests++;
        if (got !== {4'b0000, 4'b0010, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL zero_done: got %b want %b", got, {4'b0000, 4'b0010, 1'b1, 1'b0});
        end
        req = '0;
        @(negedge clk);
        got = {grant, done, busy, led_out};
        n_tests++;
        if (got !== '0) begin
            n_fail++;
            $display("FAIL zero_idle: got %b want %b", got, {(2*NR+2){1'b0}});
        end
        wait_obs(5, ok);
        e = exp_q.pop_front();
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL zero_sb: no burst observed, want %s", fmt(e));
        end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
                n_fail++;
                $display("FAIL zero_sb: got %s want %s", fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_mid_drop();
        logic [2*NR-1:0] got, want;
        burst_t e, o;
        bit ok;
        apply_reset();
        count[3:0] = 4'd2;
        req        = 4'b0001;
        exp_q.push_back('{4'b0001, 4'b0001, 16'd24, 8'd2});
        for (int j = 1; j <= 26; j++) begin
            @(negedge clk);
            want = {((j <= 24) ? 4'b0001 : 4'b0000), ((j == 25) ? 4'b0001 : 4'b0000)};
            got  = {grant, done};
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL drop_cycle_%0d: got grant/done=%b want %b", j, got, want);
            end
            if (j == 4) begin
                req        = '0;
                count[3:0] = 4'd7;
            end
        end
        wait_obs(5, ok);
        e = exp_q.pop_front();
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL drop_sb: no burst observed, want %s", fmt(e));
        end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
                n_fail++;
                $display("FAIL drop_sb: got %s want %s", fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [2*NR+1:0] got;
        burst_t e, o;
        bit ok;
        apply_reset();
        count = {4'd1, 4'd1, 4'd1, 4'd3};
        req   = 4'b0001;
        repeat (2) @(negedge clk);
        n_tests++;
        if (led_out !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_on: got led=%b want 1", led_out);
        end
        rst = 1'b1;
        req = 4'b1111;
        @(negedge clk);
        got = {grant, done, busy, led_out};
        n_tests++;
        if (got !== '0) begin
            n_fail++;
            $display("FAIL rstmid_clear: got %b want %b", got, {(2*NR+2){1'b0}});
        end
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({grant, busy} !== {4'b0001, 1'b1} || obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL rstmid_first: got grant=%b busy=%b pending_done=%0d want grant=0001 busy=1 pending_done=0",
                     grant, busy, obs_q.size());
        end
        req = '0;
        exp_q.push_back('{4'b0001, 4'b0001, 16'd32, 8'd3});
        wait_obs(60, ok);
        e = exp_q.pop_front();
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rstmid_sb: no burst observed, want %s", fmt(e));
        end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
                n_fail++;
                $display("FAIL rstmid_sb: got %s want %s", fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_max_count();
        burst_t e, o;
        bit ok;
        apply_reset();
        count[15:12] = 4'd15;
        req          = 4'b1000;
        exp_q.push_back('{4'b1000, 4'b1000, 16'd128, 8'd15});
        wait_obs(200, ok);
        req = '0;
        e = exp_q.pop_front();
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL max_sb: no burst observed, want %s", fmt(e));
        end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
                n_fail++;
                $display("FAIL max_sb: got %s want %s", fmt(o), fmt(e));
            end
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if ({busy, led_out, grant} !== '0) begin
            n_fail++;
            $display("FAIL max_idle: got busy=%b led=%b grant=%b want all 0", busy, led_out, grant);
        end
    endtask

    initial begin
        rst   = 1'b1;
        req   = '0;
        count = '0;
        @(negedge clk);
        test_reset();
        test_single_burst();
        test_round_robin();
        test_zero_count();
        test_mid_drop();
        test_reset_mid_burst();
        test_max_count();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
